cdc_pulse_rx: RTL and testbench

- Destination-domain receiver for single-bit events crossing from another clock domain.
- The source end either stretches a fast pulse into a level (MODE=0) or flips a toggle (MODE=1).
- This block synchronizes that async line and detects each event, then queues events as a valid/ready stream for local logic.
- It returns an ack level to the source so the source can pace its sends; it also counts events and flags drops.

---
 rtl/cdc_pkg.sv | 14 +
 rtl/cdc_sync_bit.sv | 25 ++
 rtl/cdc_pulse_rx.sv | 108 ++++++++++
 tb/tb_cdc_pulse_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants for the single-bit event CDC blocks (receiver and senders).
package cdc_pkg;

   // Encoding of the source-side signalling style.
   localparam int MODE_LEVEL  = 0;
   localparam int MODE_TOGGLE = 1;

   // Default synchronizer depth for req/ack lines.
   localparam int SYNC_STAGES_DEFAULT = 2;

   // Width of pending-event counters, shared with the sender side.
   localparam int PEND_W = 4;

endpackage : cdc_pkg

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for one asynchronous bit, async active-low reset.
// Only stage 0 samples the asynchronous input.
module cdc_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_async,
   output logic q
);

   logic [STAGES-1:0] sync_q;

   // Shift the async bit through the chain; the last stage is the clean copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_async};
      end
   end

   assign q = sync_q[STAGES-1];

endmodule : cdc_sync_bit

// File: rtl/cdc_pulse_rx.sv
// Destination-side receiver for single-bit events crossing clock domains.
// Synchronizes req_async, detects events (rising edge or toggle), queues them
// as a pending count offered on a valid/ready stream, counts accepted events
// and flags events dropped while the queue is full.
//
// Handshake: an event is transferred on every clk edge where evt_vld and
// evt_rdy are both high; evt_vld only depends on registered state.
module cdc_pulse_rx
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
   parameter int MODE        = MODE_LEVEL,
   parameter int MAX_PEND    = 4,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_async,
   output logic              ack,
   output logic              evt_vld,
   input  logic              evt_rdy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic [CNT_W-1:0]  evt_cnt,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam logic [PEND_W-1:0] MAX_PEND_L = PEND_W'(MAX_PEND);

   logic              s;
   logic              s_d_q;
   logic              edge_det;
   logic              pop;
   logic              full;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;

   cdc_sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_async (req_async),
      .q       (s)
   );

   // Edge history of the synchronized line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d_q <= 1'b0;
      end else begin
         s_d_q <= s;
      end
   end

   // Toggle sources signal on both edges; level sources on the rising edge only.
   generate
      if (MODE == MODE_TOGGLE) begin : g_toggle
         assign edge_det = s ^ s_d_q;
      end else begin : g_level
         assign edge_det = s & ~s_d_q;
      end
   endgenerate

   assign evt_vld = (pend_q != '0);
   assign pop     = evt_vld & evt_rdy;
   assign full    = (pend_q >= MAX_PEND_L);

   // Next-state for the pending count, event counter and sticky overflow.
   // A simultaneous pop frees a slot, so an edge at full is still accepted.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_clr ? 1'b0 : ovf_q;
      if (edge_det && !pop) begin
         if (!full) begin
            pend_d = pend_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
         end else begin
            ovf_d  = 1'b1;
         end
      end else if (edge_det && pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop) begin
         pend_d = pend_q - 1'b1;
      end
   end

   // Queue, counter and overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

   assign ack      = s;
   assign pend_cnt = pend_q;
   assign evt_cnt  = cnt_q;
   assign ovf      = ovf_q;

endmodule : cdc_pulse_rx

// File: tb/tb_cdc_pulse_rx.sv
// Directed bench for cdc_pulse_rx: a toggle-mode instance carries most of the
// sequence, a level-mode instance covers stretched-pulse detection.
module tb_cdc_pulse_rx;

   logic       clk;
   logic       rst_n;

   // toggle-mode instance
   logic       req;
   logic       ack;
   logic       evt_vld;
   logic       evt_rdy;
   logic [3:0] pend_cnt;
   logic [7:0] evt_cnt;
   logic       ovf;
   logic       ovf_clr;

   // level-mode instance
   logic       req_l;
   logic       ack_l;
   logic       evt_vld_l;
   logic       evt_rdy_l;
   logic [3:0] pend_cnt_l;
   logic [7:0] evt_cnt_l;
   logic       ovf_l;
   logic       ovf_clr_l;

   int         n_assert;
   int         n_fail;
   logic [7:0] exp_q[$];
   logic [7:0] push_id;

   cdc_pulse_rx #(.SYNC_STAGES(2), .MODE(1), .MAX_PEND(4), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_async (req),
      .ack       (ack),
      .evt_vld   (evt_vld),
      .evt_rdy   (evt_rdy),
      .pend_cnt  (pend_cnt),
      .evt_cnt   (evt_cnt),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   cdc_pulse_rx #(.SYNC_STAGES(2), .MODE(0), .MAX_PEND(4), .CNT_W(8)) dut_lvl (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_async (req_l),
      .ack       (ack_l),
      .evt_vld   (evt_vld_l),
      .evt_rdy   (evt_rdy_l),
      .pend_cnt  (pend_cnt_l),
      .evt_cnt   (evt_cnt_l),
      .ovf       (ovf_l),
      .ovf_clr   (ovf_clr_l)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance n clk edges, landing 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // flip the toggle line; expected=1 queues a delivery in the scoreboard
   task automatic toggle(input bit expected);
      req = ~req;
      if (expected) begin
         exp_q.push_back(push_id);
         push_id++;
      end
   endtask

   // scoreboard: every transfer on the toggle instance must match a queued event
   always @(negedge clk) begin
      if (rst_n && evt_vld && evt_rdy) begin
         chk("sb_pop_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   end

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      push_id   = '0;
      rst_n     = 1'b0;
      req       = 1'b0;
      evt_rdy   = 1'b1;
      ovf_clr   = 1'b0;
      req_l     = 1'b0;
      evt_rdy_l = 1'b1;
      ovf_clr_l = 1'b0;

      // reset state
      tick(3);
      chk("rst_ack", ack, 0);
      chk("rst_vld", evt_vld, 0);
      chk("rst_pend", pend_cnt, 0);
      chk("rst_cnt", evt_cnt, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_vld_l", evt_vld_l, 0);
      rst_n = 1'b1;
      tick(2);

      // level event: high for 6 clk, exactly one event
      req_l = 1'b1;
      tick(1);
      chk("lvl_ack_e1", ack_l, 0);
      tick(1);
      chk("lvl_ack_e2", ack_l, 1);
      chk("lvl_vld_e2", evt_vld_l, 0);
      tick(1);
      chk("lvl_vld_e3", evt_vld_l, 1);
      tick(1);
      chk("lvl_vld_e4", evt_vld_l, 0);
      chk("lvl_cnt_e4", evt_cnt_l, 1);
      tick(2);
      req_l = 1'b0;
      tick(6);
      chk("lvl_cnt_end", evt_cnt_l, 1);
      chk("lvl_vld_end", evt_vld_l, 0);
      chk("lvl_ovf_end", ovf_l, 0);

      // three toggles 8 clk apart, consumer always ready
      for (int i = 0; i < 3; i++) begin
         toggle(1);
         tick(2);
         chk("tgl_vld_before", evt_vld, 0);
         tick(1);
         chk("tgl_vld_pulse", evt_vld, 1);
         tick(1);
         chk("tgl_vld_after", evt_vld, 0);
         tick(4);
      end
      chk("tgl_cnt", evt_cnt, 3);
      chk("tgl_ack_eq_req", ack, req);
      chk("tgl_sb_empty", exp_q.size(), 0);

      // backpressure: 5 toggles into a 4-deep queue
      evt_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         toggle(i < 4);
         tick(3);
         chk("bp_pend", pend_cnt, (i < 4) ? i + 1 : 4);
         chk("bp_ovf", ovf, (i < 4) ? 0 : 1);
         tick(1);
      end
      chk("bp_cnt", evt_cnt, 7);
      evt_rdy = 1'b1;
      tick(3);
      chk("bp_drain_vld_mid", evt_vld, 1);
      tick(1);
      chk("bp_drain_pend", pend_cnt, 0);
      chk("bp_drain_vld", evt_vld, 0);
      chk("bp_sb_empty", exp_q.size(), 0);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("bp_ovf_clr", ovf, 0);

      // simultaneous push and pop at full
      evt_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toggle(1);
         tick(4);
      end
      chk("pp_full", pend_cnt, 4);
      toggle(1);
      tick(2);
      evt_rdy = 1'b1;
      tick(1);
      evt_rdy = 1'b0;
      chk("pp_pend", pend_cnt, 4);
      chk("pp_ovf", ovf, 0);
      chk("pp_cnt", evt_cnt, 12);

      // async reset mid-flight with pend_cnt=3 and req high
      evt_rdy = 1'b1;
      tick(1);
      evt_rdy = 1'b0;
      chk("ar_pend3", pend_cnt, 3);
      chk("ar_req_high", req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_ack", ack, 0);
      chk("ar_vld", evt_vld, 0);
      chk("ar_pend", pend_cnt, 0);
      chk("ar_cnt", evt_cnt, 0);
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      exp_q.push_back(push_id);
      push_id++;
      tick(2);
      chk("ar_vld_e2", evt_vld, 0);
      tick(1);
      chk("ar_pend_e3", pend_cnt, 1);
      tick(3);
      chk("ar_pend_once", pend_cnt, 1);
      chk("ar_cnt_once", evt_cnt, 1);
      evt_rdy = 1'b1;
      tick(1);
      chk("ar_drained", pend_cnt, 0);

      // counter wrap: 255 more accepted events bring evt_cnt to 256 mod 256
      for (int i = 0; i < 255; i++) begin
         if (i == 254) chk("wrap_pre", evt_cnt, 8'hff);
         toggle(1);
         tick(4);
      end
      chk("wrap_cnt", evt_cnt, 0);
      chk("wrap_sb_empty", exp_q.size(), 0);

      // overflow set together with ovf_clr: set wins; then clear alone
      evt_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         toggle(1);
         tick(4);
      end
      toggle(0);
      tick(2);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("oc_set_wins", ovf, 1);
      chk("oc_pend", pend_cnt, 4);
      chk("oc_cnt", evt_cnt, 4);
      tick(1);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      chk("oc_clr", ovf, 0);
      evt_rdy = 1'b1;
      tick(5);
      chk("oc_drain", evt_vld, 0);
      chk("final_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_cdc_pulse_rx
